spi_fram_responder: RTL

SPI-slave model of the FRAM device that the on-chip FRAM controller talks to. It accepts FRAM-style opcodes over a 4-wire SPI mode-0 link and serves them from an internal byte array. It sits on the far side of the controller's spi_clk/spi_cs/spi_mosi/spi_miso pins, as an FPGA-emulation stand-in and a verification responder. All SPI inputs are oversampled in the system clock domain; no logic runs on spi_clk.

---
 rtl/spi_fram_responder_if.sv | 20 ++
 rtl/spi_fram_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_fram_responder_if.sv
// SPI mode-0 link between the FRAM controller (master) and the FRAM responder (slave),
// together with the responder's observable status flags.
interface spi_fram_responder_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic wel;
  logic frame_active;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, wel, frame_active
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, wel, frame_active
  );
endinterface

// File: rtl/spi_fram_responder.sv
// FRAM-style SPI mode-0 slave, fully oversampled in the clk domain.
// Serves READ/WRITE/RDSR/WREN/WRDI from an internal byte array.
module spi_fram_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_fram_responder_if.slave spi
);

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    RD_DATA,
    WR_DATA,
    STATUS,
    IGNORE
  } state_e;

  logic [1:0]    sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic          sclk_prev_q, cs_prev_q;
  logic          sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    rx_shift_q;
  logic [7:0]    tx_shift_q;
  logic [7:0]    op_q;
  logic [7:0]    addr_hi_q;
  logic [AW-1:0] addr_q;
  logic          wel_q, miso_q, frame_active_q;

  logic [7:0]    rx_byte_d, status_byte_d, rd_byte_d;
  logic [15:0]   addr_word_d;
  logic [AW-1:0] addr_load_d, addr_inc_d, rd_addr_d;
  logic          byte_done, mem_we, addr_unused;

  logic [7:0]    mem_q [DEPTH];

  // CS history resets low so a CS held low through reset never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi.spi_clk};
      cs_sync_q   <= {cs_sync_q[0], spi.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
  assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;
  assign mosi_s    = mosi_sync_q[1];

  assign rx_byte_d     = {rx_shift_q, mosi_s};
  assign byte_done     = sclk_rise && (bit_cnt_q == 3'd7);
  assign status_byte_d = {6'b0, wel_q, 1'b0};

  // Only the low AW bits of the protocol address select a byte.
  assign addr_word_d = {addr_hi_q, rx_byte_d};
  assign addr_load_d = addr_word_d[AW-1:0];
  assign addr_unused = ^addr_word_d;
  assign addr_inc_d  = addr_q + 1'b1;

  assign rd_addr_d = (state_q == ADDR_LO) ? addr_load_d : addr_inc_d;
  assign rd_byte_d = mem_q[rd_addr_d];

  assign mem_we = byte_done && !cs_rise && (state_q == WR_DATA) && wel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      op_q           <= '0;
      addr_hi_q      <= '0;
      addr_q         <= '0;
      wel_q          <= 1'b0;
      miso_q         <= 1'b0;
      frame_active_q <= 1'b0;
    end else if (cs_rise) begin
      // A coincident spi_clk rise is dropped here, so a partial byte never commits.
      if (state_q == IGNORE && op_q == OP_WREN) begin
        wel_q <= 1'b1;
      end else if (state_q == IGNORE && op_q == OP_WRDI) begin
        wel_q <= 1'b0;
      end else if (state_q == WR_DATA) begin
        wel_q <= 1'b0;
      end
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      miso_q         <= 1'b0;
      frame_active_q <= 1'b0;
    end else if (cs_fall) begin
      state_q        <= CMD;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      op_q           <= '0;
      miso_q         <= 1'b0;
      frame_active_q <= 1'b1;
    end else if (state_q != IDLE) begin
      if (sclk_rise) begin
        rx_shift_q <= rx_byte_d[6:0];
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              op_q <= rx_byte_d;
              case (rx_byte_d)
                OP_READ, OP_WRITE: state_q <= ADDR_HI;
                OP_RDSR: begin
                  state_q    <= STATUS;
                  tx_shift_q <= status_byte_d;
                end
                default: state_q <= IGNORE;
              endcase
            end
            ADDR_HI: begin
              addr_hi_q <= rx_byte_d;
              state_q   <= ADDR_LO;
            end
            ADDR_LO: begin
              addr_q <= addr_load_d;
              if (op_q == OP_READ) begin
                state_q    <= RD_DATA;
                tx_shift_q <= rd_byte_d;
              end else begin
                state_q <= WR_DATA;
              end
            end
            RD_DATA: begin
              addr_q     <= addr_inc_d;
              tx_shift_q <= rd_byte_d;
            end
            WR_DATA: addr_q     <= addr_inc_d;
            STATUS:  tx_shift_q <= status_byte_d;
            default: ;
          endcase
        end
      end else if (sclk_fall) begin
        if (state_q == RD_DATA || state_q == STATUS) begin
          miso_q     <= tx_shift_q[7];
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= rx_byte_d;
    end
  end

  assign spi.spi_miso     = miso_q;
  assign spi.wel          = wel_q;
  assign spi.frame_active = frame_active_q;

endmodule
